// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM states, the
// register-zero address, and the latch-control bundle with its canned patterns.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } ctrlState_e;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pcEn;
        logic fdEn;
        logic dxEn;
        logic xmEn;
        logic mwEn;
        logic fdFlush;
        logic dxFlush;
        logic xmFlush;
    } latchCtrl_t;

    // Bit order follows the struct: {pc,fd,dx,xm,mw enables, fd,dx,xm flushes}.
    localparam latchCtrl_t CTL_RUN      = 8'b11111_000;
    localparam latchCtrl_t CTL_FREEZE   = 8'b00000_000;
    localparam latchCtrl_t CTL_SQUASH   = 8'b11111_110;
    localparam latchCtrl_t CTL_MD_HOLD  = 8'b00011_001;
    localparam latchCtrl_t CTL_LOAD_USE = 8'b00111_010;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in DX whose destination feeds the
// instruction in FD. Shared with the forwarding unit.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            dx_is_load,
    input  logic [RA_W-1:0] dx_rd,
    input  logic [RA_W-1:0] fd_rs,
    input  logic [RA_W-1:0] fd_rt,
    input  logic            fd_uses_rs,
    input  logic            fd_uses_rt,
    output logic            loadUse
);

    logic rsHit;
    logic rtHit;

    assign rsHit   = fd_uses_rs && (fd_rs == dx_rd);
    assign rtHit   = fd_uses_rt && (fd_rt == dx_rd);
    // r0 is hardwired, so a load targeting it can never feed a consumer.
    assign loadUse = dx_is_load && (dx_rd != RA_W'(REG_ZERO)) && (rsHit || rtHit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy latch controls from a
// RUN/MD_WAIT FSM with a memory-freeze overlay, plus saturating perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dx_is_load,
    input  logic [RA_W-1:0]   dx_rd,
    input  logic [RA_W-1:0]   fd_rs,
    input  logic [RA_W-1:0]   fd_rt,
    input  logic              fd_uses_rs,
    input  logic              fd_uses_rt,
    input  logic              md_start,
    input  logic              md_ready,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              fd_en,
    output logic              dx_en,
    output logic              xm_en,
    output logic              mw_en,
    output logic              fd_flush,
    output logic              dx_flush,
    output logic              xm_flush,
    output logic              md_error,
    output logic [PERF_W-1:0] stall_count,
    output logic [PERF_W-1:0] flush_count
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    ctrlState_e       state, nextState;
    logic [CNT_W-1:0] mdCnt, mdCntNext;
    logic             mdDone, mdDoneNext, mdErrorNext;
    logic             memFreeze, loadUse, mdTimeout, flushInc;
    latchCtrl_t       ctl;

    hazard_detect #(.RA_W(RA_W)) uHazard (
        .dx_is_load (dx_is_load),
        .dx_rd      (dx_rd),
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rs (fd_uses_rs),
        .fd_uses_rt (fd_uses_rt),
        .loadUse    (loadUse)
    );

    assign memFreeze = mem_req && !mem_ack;
    assign mdTimeout = (mdCnt == CNT_W'(MD_TIMEOUT));

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        ctl         = CTL_RUN;
        nextState   = state;
        mdCntNext   = mdCnt;
        mdDoneNext  = mdDone;
        mdErrorNext = md_error;
        flushInc    = 1'b0;

        unique case (state)
            ST_RUN: begin
                if (memFreeze) begin
                    ctl = CTL_FREEZE;
                end else if (branch_taken) begin
                    // Any stalled load-use consumer is wrong-path and gets squashed.
                    ctl      = CTL_SQUASH;
                    flushInc = 1'b1;
                end else if (md_start) begin
                    ctl       = CTL_MD_HOLD;
                    nextState = ST_MD_WAIT;
                    mdCntNext = CNT_W'(1);
                end else if (loadUse) begin
                    ctl = CTL_LOAD_USE;
                end
            end

            ST_MD_WAIT: begin
                if (!mdTimeout) mdCntNext = mdCnt + CNT_W'(1);
                if (memFreeze) begin
                    ctl = CTL_FREEZE;
                    if (md_ready) mdDoneNext = 1'b1;
                end else if (md_ready || mdDone || mdTimeout) begin
                    ctl        = CTL_RUN;
                    nextState  = ST_RUN;
                    mdDoneNext = 1'b0;
                    if (!(md_ready || mdDone)) mdErrorNext = 1'b1;
                end else begin
                    ctl = CTL_MD_HOLD;
                end
            end

            default: nextState = ST_RUN;
        endcase
    end

    // While reset is low every latch is held and loaded with a NOP.
    assign pc_en    = reset & ctl.pcEn;
    assign fd_en    = reset & ctl.fdEn;
    assign dx_en    = reset & ctl.dxEn;
    assign xm_en    = reset & ctl.xmEn;
    assign mw_en    = reset & ctl.mwEn;
    assign fd_flush = ~reset | ctl.fdFlush;
    assign dx_flush = ~reset | ctl.dxFlush;
    assign xm_flush = ~reset | ctl.xmFlush;

    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            mdCnt    <= '0;
            mdDone   <= 1'b0;
            md_error <= 1'b0;
        end else begin
            state    <= nextState;
            mdCnt    <= mdCntNext;
            mdDone   <= mdDoneNext;
            md_error <= mdErrorNext;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!ctl.pcEn && !(&stall_count)) stall_count <= stall_count + PERF_W'(1);
            if (flushInc && !(&flush_count))  flush_count <= flush_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pipeline_ctrl;

    localparam int RA_W       = 5;
    localparam int MD_TIMEOUT = 64;
    localparam int PERF_W     = 8;
    localparam int PMAX       = (1 << PERF_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              dx_is_load, fd_uses_rs, fd_uses_rt;
    logic [RA_W-1:0]   dx_rd, fd_rs, fd_rt;
    logic              md_start, md_ready, branch_taken, mem_req, mem_ack;
    logic              pc_en, fd_en, dx_en, xm_en, mw_en;
    logic              fd_flush, dx_flush, xm_flush, md_error;
    logic [PERF_W-1:0] stall_count, flush_count;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: "is a mult/div outstanding", how long it has waited,
    // whether its result already arrived, the sticky error and the counters.
    bit         mInMd, mReadySeen, mErr;
    int         mWait, mStall, mFlush;
    logic [7:0] cmpExp;

    pipeline_ctrl #(.RA_W(RA_W), .MD_TIMEOUT(MD_TIMEOUT), .PERF_W(PERF_W)) dut (
        .clock(clock), .reset(reset),
        .dx_is_load(dx_is_load), .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .md_start(md_start), .md_ready(md_ready), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_error(md_error), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctlVec();
        return {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush};
    endfunction

    // Expected latch controls from the priority rules, given model state and inputs.
    function automatic logic [7:0] expCtl();
        bit frozen, hazard;
        frozen = mem_req && !mem_ack;
        hazard = dx_is_load && (dx_rd != 0) &&
                 ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
        if (frozen)                                             return 8'b00000_000;
        if (mInMd) begin
            if (mReadySeen || md_ready || mWait >= MD_TIMEOUT) return 8'b11111_000;
            return 8'b00011_001;
        end
        if (branch_taken)                                       return 8'b11111_110;
        if (md_start)                                           return 8'b00011_001;
        if (hazard)                                             return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    task automatic modelStep(input logic [7:0] e);
        bit frozen, released;
        frozen = mem_req && !mem_ack;
        if (!e[7] && mStall < PMAX) mStall++;
        if (!mInMd) begin
            if (!frozen && branch_taken) begin
                if (mFlush < PMAX) mFlush++;
            end else if (!frozen && md_start) begin
                mInMd = 1;
                mWait = 1;
            end
        end else begin
            released = mReadySeen || md_ready || (mWait >= MD_TIMEOUT);
            if (frozen) begin
                if (md_ready) mReadySeen = 1;
                mWait++;
            end else if (released) begin
                if (!(mReadySeen || md_ready)) mErr = 1;
                mInMd      = 0;
                mReadySeen = 0;
            end else begin
                mWait++;
            end
        end
    endtask

    // Compare process: inputs are stable across the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("reset_ctl",   ctlVec(),    8'b00000_111);
            check("reset_stall", stall_count, 0);
            check("reset_flush", flush_count, 0);
            check("reset_err",   md_error,    0);
            mInMd = 0; mReadySeen = 0; mErr = 0; mWait = 0; mStall = 0; mFlush = 0;
        end else begin
            check("stall_count", stall_count, mStall);
            check("flush_count", flush_count, mFlush);
            check("md_error",    md_error,    mErr);
            cmpExp = expCtl();
            check("latch_ctl",   ctlVec(),    cmpExp);
            modelStep(cmpExp);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        dx_is_load = 0; dx_rd = 0; fd_rs = 0; fd_rt = 0; fd_uses_rs = 0; fd_uses_rt = 0;
        md_start = 0; md_ready = 0; branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic setLoadUse();
        dx_is_load = 1; dx_rd = 8; fd_rs = 8; fd_uses_rs = 1;
    endtask

    initial begin
        int waitIdx;
        idle();
        reset = 0;
        cyc(); cyc();
        check("lit_reset_ctl", ctlVec(), 8'b00000_111);
        reset = 1;
        cyc();

        // Load-use on r8 stalls one cycle; the same pattern on r0 does not.
        setLoadUse(); #1;
        check("lit_lu_ctl", ctlVec(), 8'b00111_010);
        cyc(); idle(); #1;
        check("lit_lu_stall", stall_count, 1);
        dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_uses_rs = 1; #1;
        check("lit_r0_ctl", pc_en, 1);
        cyc(); idle();
        check("lit_r0_stall", stall_count, 1);

        // Branch wins over a coincident load-use.
        setLoadUse(); branch_taken = 1; #1;
        check("lit_br_ctl", ctlVec(), 8'b11111_110);
        cyc(); idle();
        check("lit_br_flush", flush_count, 1);
        check("lit_br_stall", stall_count, 1);

        // Mult/div with ready five cycles after start.
        md_start = 1; #1;
        check("lit_md_start", ctlVec(), 8'b00011_001);
        cyc(); md_start = 0;
        for (int i = 0; i < 4; i++) begin
            check("lit_md_hold", ctlVec(), 8'b00011_001);
            cyc();
        end
        md_ready = 1; #1;
        check("lit_md_exit", ctlVec(), 8'b11111_000);
        cyc(); idle();
        check("lit_md_run", pc_en, 1);
        check("lit_md_stall", stall_count, 6);

        // Ready arrives during a memory freeze; exit on the first unfrozen cycle.
        md_start = 1; cyc(); md_start = 0;
        cyc(); cyc();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            md_ready = (i == 0);
            #1;
            check("lit_frz_ctl", ctlVec(), 8'b00000_000);
            cyc();
        end
        md_ready = 0; mem_ack = 1; #1;
        check("lit_frz_exit", ctlVec(), 8'b11111_000);
        cyc(); idle();
        check("lit_frz_stall", stall_count, 12);

        // Reset asserted mid-MD_WAIT with md_cnt at 10.
        md_start = 1; cyc(); md_start = 0;
        for (int i = 0; i < 9; i++) cyc();
        reset = 0; #1;
        check("lit_rst_ctl", ctlVec(), 8'b00000_111);
        cyc(); reset = 1; cyc();
        check("lit_rst_stall", stall_count, 0);
        check("lit_rst_err", md_error, 0);
        check("lit_rst_run", pc_en, 1);

        // Timeout: no ready, release on the 64th wait cycle, error sticks.
        md_start = 1; cyc(); md_start = 0;
        waitIdx = 0;
        for (int i = 1; i <= 100; i++) begin
            if (pc_en) begin
                waitIdx = i;
                break;
            end
            cyc();
        end
        check("lit_to_cycle", waitIdx, MD_TIMEOUT);
        cyc();
        check("lit_to_err", md_error, 1);
        for (int i = 0; i < 5; i++) cyc();
        check("lit_to_sticky", md_error, 1);

        // Saturation of both counters.
        setLoadUse();
        for (int i = 0; i < 300; i++) cyc();
        idle();
        check("lit_stall_sat", stall_count, PMAX);
        branch_taken = 1;
        for (int i = 0; i < 300; i++) cyc();
        idle();
        check("lit_flush_sat", flush_count, PMAX);
        check("lit_stall_hold", stall_count, PMAX);

        reset = 0; cyc(); reset = 1;

        // Randomized traffic with three md_ready densities (dense, sparse, near-timeout).
        for (int ph = 0; ph < 3; ph++) begin
            int readyDiv;
            readyDiv = (ph == 0) ? 3 : (ph == 1) ? 30 : 300;
            for (int n = 0; n < 1000; n++) begin
                if ($urandom_range(0, 599) == 0) reset = 0;
                else                             reset = 1;
                dx_is_load   = ($urandom_range(0, 1) == 1);
                dx_rd        = RA_W'($urandom_range(0, 3));
                fd_rs        = RA_W'($urandom_range(0, 3));
                fd_rt        = RA_W'($urandom_range(0, 3));
                fd_uses_rs   = ($urandom_range(0, 1) == 1);
                fd_uses_rt   = ($urandom_range(0, 1) == 1);
                md_start     = ($urandom_range(0, 5) == 0);
                md_ready     = ($urandom_range(0, readyDiv) == 0);
                branch_taken = ($urandom_range(0, 5) == 0);
                mem_req      = ($urandom_range(0, 2) == 0);
                mem_ack      = ($urandom_range(0, 1) == 1);
                cyc();
            end
        end
        idle();
        reset = 1;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
